// File: rtl/cic_decimator.sv
// Multi-channel decimating CIC filter. It uses pipelined integrators, a strobed comb chain,
// and a round-half-up output stage that saturates to OWIDTH.
module cic_decimator #(
    parameter int ORDER  = 3,
    parameter int R      = 8,
    parameter int DM     = 1,
    parameter int WIDTH  = 16,
    parameter int OWIDTH = 16,
    parameter int CH     = 2
) (
    input  logic                  reset,
    input  logic                  clk_in,
    input  logic                  in_valid,
    input  logic [CH*WIDTH-1:0]   in,
    output logic                  out_valid,
    output logic [CH*OWIDTH-1:0]  out,
    output logic [CH-1:0]         out_sat
);
    localparam int unsigned G  = $clog2((R * DM) ** ORDER);
    localparam int unsigned AW = WIDTH + G;
    localparam int unsigned S  = AW - OWIDTH;
    localparam int unsigned CW = $clog2(R);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ORDER:0]       stb_q, stb_d;
    logic signed [AW-1:0] integ_q [CH][ORDER];
    logic signed [AW-1:0] integ_d [CH][ORDER];
    logic signed [AW-1:0] comb_q  [CH][ORDER];
    logic signed [AW-1:0] comb_d  [CH][ORDER];
    logic signed [AW-1:0] dly_q   [CH][ORDER][DM];
    logic signed [AW-1:0] dly_d   [CH][ORDER][DM];
    logic signed [AW-1:0] tap     [CH][ORDER];
    logic [CH*OWIDTH-1:0] out_q, out_d;
    logic [CH-1:0]        out_sat_q, out_sat_d;
    logic                 out_valid_q, out_valid_d;
    logic [CH*OWIDTH-1:0] res_w;
    logic [CH-1:0]        clip_w;

    // Each integrator stage adds the previous stage's registered value, which gives one stage of pipelining per integrator.
    always_comb begin
        integ_d = integ_q;
        if (in_valid) begin
            for (int c = 0; c < CH; c++) begin
                integ_d[c][0] = integ_q[c][0] + AW'($signed(in[c*WIDTH +: WIDTH]));
                for (int k = 1; k < ORDER; k++) begin
                    integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
                end
            end
        end
    end

    // A strobe is launched on the sample that completes each group of R accepted samples.
    always_comb begin
        cnt_d = cnt_q;
        stb_d = {stb_q[ORDER-1:0], 1'b0};
        if (in_valid) begin
            if (cnt_q == CW'(R - 1)) begin
                cnt_d    = '0;
                stb_d[0] = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            tap[c][0] = integ_q[c][ORDER-1];
            for (int k = 1; k < ORDER; k++) begin
                tap[c][k] = comb_q[c][k-1];
            end
        end
    end

    // Comb k fires on stb[k] and subtracts the oldest entry of its DM-deep delay line.
    always_comb begin
        comb_d = comb_q;
        dly_d  = dly_q;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < ORDER; k++) begin
                if (stb_q[k]) begin
                    comb_d[c][k]   = tap[c][k] - dly_q[c][k][DM-1];
                    dly_d[c][k][0] = tap[c][k];
                    for (int j = 1; j < DM; j++) begin
                        dly_d[c][k][j] = dly_q[c][k][j-1];
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        if (S == 0) begin : g_full
            assign res_w[c*OWIDTH +: OWIDTH] = comb_q[c][ORDER-1];
            assign clip_w[c]                 = 1'b0;
        end else begin : g_rnd
            localparam logic signed [AW:0] HALF = (AW+1)'(1) <<< (S - 1);
            localparam logic signed [AW:0] MAXV = ((AW+1)'(1) <<< (OWIDTH - 1)) - (AW+1)'(1);
            localparam logic signed [AW:0] MINV = ~MAXV;
            logic signed [AW:0] sum;
            logic signed [AW:0] shr;
            // One guard bit keeps the rounding add from wrapping.
            assign sum = {comb_q[c][ORDER-1][AW-1], comb_q[c][ORDER-1]} + HALF;
            assign shr = sum >>> S;
            assign clip_w[c] = (shr > MAXV) || (shr < MINV);
            assign res_w[c*OWIDTH +: OWIDTH] = (shr > MAXV) ? OWIDTH'(MAXV) :
                                               (shr < MINV) ? OWIDTH'(MINV) : OWIDTH'(shr);
        end
    end

    always_comb begin
        out_d       = out_q;
        out_sat_d   = out_sat_q;
        out_valid_d = stb_q[ORDER];
        if (stb_q[ORDER]) begin
            out_d     = res_w;
            out_sat_d = clip_w;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            stb_q       <= '0;
            out_q       <= '0;
            out_sat_q   <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    integ_q[c][k] <= '0;
                    comb_q[c][k]  <= '0;
                    for (int j = 0; j < DM; j++) begin
                        dly_q[c][k][j] <= '0;
                    end
                end
            end
        end else begin
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            out_q       <= out_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            integ_q     <= integ_d;
            comb_q      <= comb_d;
            dly_q       <= dly_d;
        end
    end

    assign out       = out_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator. It runs three configurations. Reference outputs come from a direct FIR
// convolution with the CIC impulse response, plus hand-computed DC vectors.
module tb_cic_decimator;
    localparam int ORD [3] = '{3, 3, 4};
    localparam int RR  [3] = '{4, 4, 5};
    localparam int DMV [3] = '{1, 1, 2};
    localparam int OW  [3] = '{14, 4, 10};
    localparam int AWV [3] = '{14, 14, 22};

    logic        clk_in = 1'b0;
    logic [2:0]  rst = '0;
    logic [2:0]  iv = '0;
    logic [15:0] din [3];
    logic        ov_a, ov_b, ov_c;
    logic [27:0] out_a;
    logic [7:0]  out_b;
    logic [19:0] out_c;
    logic [1:0]  sat_a, sat_b, sat_c;

    always #5 clk_in = ~clk_in;

    cic_decimator #(.ORDER(3), .R(4), .DM(1), .WIDTH(8), .OWIDTH(14), .CH(2)) u_a (
        .reset(rst[0]), .clk_in(clk_in), .in_valid(iv[0]), .in(din[0]),
        .out_valid(ov_a), .out(out_a), .out_sat(sat_a));
    cic_decimator #(.ORDER(3), .R(4), .DM(1), .WIDTH(8), .OWIDTH(4), .CH(2)) u_b (
        .reset(rst[1]), .clk_in(clk_in), .in_valid(iv[1]), .in(din[1]),
        .out_valid(ov_b), .out(out_b), .out_sat(sat_b));
    cic_decimator #(.ORDER(4), .R(5), .DM(2), .WIDTH(8), .OWIDTH(10), .CH(2)) u_c (
        .reset(rst[2]), .clk_in(clk_in), .in_valid(iv[2]), .in(din[2]),
        .out_valid(ov_c), .out(out_c), .out_sat(sat_c));

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          samp [3][2][0:4095];
    longint      h [3][0:63];
    int          hlen [3];
    int          nacc [3];
    int          nout [3];
    int          npulse [3];
    int          exp_cyc [3][$];
    int          pulse_q [$];
    logic [63:0] last_out [3];
    logic [1:0]  last_sat [3];

    typedef struct {
        int         k;
        int         a;
        int         b;
        int         ea;
        int         eb;
        logic [1:0] es;
    } vec_t;

    task automatic chk(input string name, input longint got, input longint expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    function automatic longint sx(input logic [63:0] v, input int w);
        longint r;
        r = longint'(v & ((64'd1 << w) - 64'd1));
        if (v[w-1]) r = r - longint'(64'd1 << w);
        return r;
    endfunction

    // Impulse response: N-fold convolution of a length R*DM boxcar.
    function automatic void build_h(input int k);
        longint t [0:63];
        int rd;
        rd = RR[k] * DMV[k];
        for (int i = 0; i < 64; i++) h[k][i] = 0;
        h[k][0] = 1;
        hlen[k] = 1;
        for (int s = 0; s < ORD[k]; s++) begin
            for (int i = 0; i < 64; i++) t[i] = 0;
            for (int i = 0; i < hlen[k]; i++)
                for (int j = 0; j < rd; j++) t[i+j] += h[k][i];
            hlen[k] += rd - 1;
            for (int i = 0; i < 64; i++) h[k][i] = t[i];
        end
    endfunction

    // Output m sees the convolution at sample (m+1)R-1, delayed by ORDER-1 for the integrator pipeline.
    function automatic void ref_out(input int k, input int ch, input int m,
                                    output longint v, output logic s);
        int p;
        int sh;
        longint acc;
        longint md;
        longint mx;
        p   = (m + 1) * RR[k] - 1 - (ORD[k] - 1);
        acc = 0;
        for (int j = 0; j < hlen[k]; j++)
            if (p - j >= 0) acc += h[k][j] * longint'(samp[k][ch][p-j]);
        md  = longint'(1) << AWV[k];
        acc = acc & (md - 1);
        if (acc >= md / 2) acc -= md;
        s  = 1'b0;
        sh = AWV[k] - OW[k];
        if (sh > 0) begin
            acc = (acc + (longint'(1) << (sh - 1))) >>> sh;
            mx  = (longint'(1) << (OW[k] - 1)) - 1;
            if (acc > mx) begin acc = mx; s = 1'b1; end
            else if (acc < -mx - 1) begin acc = -mx - 1; s = 1'b1; end
        end
        v = acc;
    endfunction

    function automatic logic [63:0] out_of(input int k);
        case (k)
            0:       return 64'(out_a);
            1:       return 64'(out_b);
            default: return 64'(out_c);
        endcase
    endfunction

    task automatic drive(input int k, input logic v, input int a, input int b);
        @(negedge clk_in);
        iv[k]  = v;
        din[k] = {8'(b), 8'(a)};
        if (v) begin
            samp[k][0][nacc[k]] = a;
            samp[k][1][nacc[k]] = b;
            if (nacc[k] % RR[k] == RR[k] - 1) exp_cyc[k].push_back(cyc + ORD[k] + 2);
            nacc[k]++;
        end
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) drive(k, 1'b0, 0, 0);
    endtask

    task automatic do_reset(input int k);
        @(negedge clk_in);
        iv[k]  = 1'b0;
        rst[k] = 1'b1;
        nacc[k] = 0;
        nout[k] = 0;
        npulse[k] = 0;
        exp_cyc[k].delete();
        last_out[k] = '0;
        last_sat[k] = '0;
        @(negedge clk_in);
        rst[k] = 1'b0;
    endtask

    task automatic mon(input int k, input logic ov, input logic [63:0] ob, input logic [1:0] sb);
        longint ev;
        logic   es;
        bit     due;
        due = (exp_cyc[k].size() > 0) && (exp_cyc[k][0] == cyc);
        if (ov) begin
            n_checks++;
            if (!due) begin
                n_fail++;
                $display("FAIL i%0d pulse_timing: out_valid at cycle %0d, next expected cycle %0d",
                         k, cyc, (exp_cyc[k].size() > 0) ? exp_cyc[k][0] : -1);
            end else begin
                void'(exp_cyc[k].pop_front());
            end
            for (int ch = 0; ch < 2; ch++) begin
                ref_out(k, ch, nout[k], ev, es);
                chk($sformatf("i%0d ch%0d data m=%0d", k, ch, nout[k]), sx(ob >> (ch * OW[k]), OW[k]), ev);
                chk($sformatf("i%0d ch%0d sat m=%0d", k, ch, nout[k]), longint'(sb[ch]), longint'(es));
            end
            last_out[k] = ob;
            last_sat[k] = sb;
            nout[k]++;
            npulse[k]++;
            if (k == 0) pulse_q.push_back(cyc);
        end else begin
            if (due) begin
                n_checks++;
                n_fail++;
                $display("FAIL i%0d missing_pulse: no out_valid at cycle %0d", k, cyc);
                void'(exp_cyc[k].pop_front());
                nout[k]++;
            end
            chk($sformatf("i%0d hold", k), longint'(ob), longint'(last_out[k]));
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(posedge clk_in) begin
        #1;
        mon(0, ov_a, 64'(out_a), sat_a);
        mon(1, ov_b, 64'(out_b), sat_b);
        mon(2, ov_c, 64'(out_c), sat_c);
    end

    initial begin
        vec_t vt [8];
        int   k;
        int   acc;
        vt[0] = '{0,    1,   -1,    64,   -64, 2'b00};
        vt[1] = '{0, -128,    0, -8192,     0, 2'b00};
        vt[2] = '{0,  127,    5,  8128,   320, 2'b00};
        vt[3] = '{0,    0, -128,     0, -8192, 2'b00};
        vt[4] = '{1,  127, -128,     7,    -8, 2'b01};
        vt[5] = '{1, -128,  127,    -8,     7, 2'b10};
        vt[6] = '{1,    8,   -8,     1,     0, 2'b00};
        vt[7] = '{1,   16,  -16,     1,    -1, 2'b00};
        for (int i = 0; i < 3; i++) begin
            din[i] = '0;
            last_out[i] = '0;
            last_sat[i] = '0;
            nacc[i] = 0;
            nout[i] = 0;
            npulse[i] = 0;
            build_h(i);
        end

        // Reset state
        #1 rst = '1;
        #1;
        chk("reset out_a", longint'(out_a), 0);
        chk("reset ov_a", longint'(ov_a), 0);
        chk("reset sat_a", longint'(sat_a), 0);
        chk("reset out_b", longint'(out_b), 0);
        chk("reset out_c", longint'(out_c), 0);
        chk("reset ov_c", longint'(ov_c), 0);
        repeat (2) @(negedge clk_in);
        rst = '0;

        // DC vectors, settled outputs
        for (int i = 0; i < 8; i++) begin
            k = vt[i].k;
            do_reset(k);
            for (int n = 0; n < 12 * RR[k]; n++) drive(k, 1'b1, vt[i].a, vt[i].b);
            idle(k, 10);
            chk($sformatf("dc%0d ch0", i), sx(out_of(k), OW[k]), vt[i].ea);
            chk($sformatf("dc%0d ch1", i), sx(out_of(k) >> OW[k], OW[k]), vt[i].eb);
            chk($sformatf("dc%0d sat", i), longint'(last_sat[k]), longint'(vt[i].es));
            chk($sformatf("dc%0d pulses", i), npulse[k], 12);
        end

        // in_valid every other cycle
        do_reset(0);
        pulse_q.delete();
        for (int n = 0; n < 40; n++) begin
            drive(0, 1'b1, 1, -1);
            drive(0, 1'b0, 0, 0);
        end
        idle(0, 10);
        chk("gap pulse count", pulse_q.size(), 10);
        for (int i = 1; i < pulse_q.size(); i++)
            chk($sformatf("gap spacing %0d", i), pulse_q[i] - pulse_q[i-1], 8);
        chk("gap ch0 final", sx(out_a, 14), 64);

        // Reset two cycles after an accepting edge drops that strobe
        do_reset(0);
        for (int n = 0; n < 10; n++) drive(0, 1'b1, 5, -3);
        chk("pre-reset pulses", npulse[0], 1);
        @(negedge clk_in);
        iv[0]  = 1'b0;
        rst[0] = 1'b1;
        nacc[0] = 0;
        nout[0] = 0;
        npulse[0] = 0;
        exp_cyc[0].delete();
        last_out[0] = '0;
        last_sat[0] = '0;
        #1;
        chk("midreset out", longint'(out_a), 0);
        chk("midreset ov", longint'(ov_a), 0);
        chk("midreset sat", longint'(sat_a), 0);
        @(negedge clk_in);
        rst[0] = 1'b0;
        idle(0, 6);
        chk("no stale pulse", npulse[0], 0);
        for (int n = 0; n < 4; n++) drive(0, 1'b1, 2, 1);
        idle(0, 8);
        chk("post-reset pulses", npulse[0], 1);
        chk("post-reset ch0", sx(out_a, 14), 8);
        chk("post-reset ch1", sx(out_a >> 14, 14), 4);

        // Random stream with random in_valid on ORDER=4 R=5 DM=2
        do_reset(2);
        acc = 0;
        for (int t = 0; t < 20000 && acc < 2000; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                drive(2, 1'b1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
                acc++;
            end else begin
                drive(2, 1'b0, 0, 0);
            end
        end
        idle(2, 20);
        chk("rand accepted", acc, 2000);
        chk("rand pulses", npulse[2], 400);

        for (int i = 0; i < 3; i++)
            chk($sformatf("i%0d pending pulses", i), exp_cyc[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
